// File: rtl/ac97_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ac97_pkg : AC97 frame geometry, tag bit indices and receiver state type    |
// | rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
package ac97_pkg;

    localparam int SLOT0_W     = 16;
    localparam int SLOT_W      = 20;
    localparam int FRAME_BITS  = 256;
    localparam int RX_LAST_BIT = 95;
    localparam int RX_BITS     = RX_LAST_BIT + 1;

    localparam int TAG_READY = 15;
    localparam int TAG_SLOT1 = 14;
    localparam int TAG_SLOT2 = 13;
    localparam int TAG_SLOT3 = 12;
    localparam int TAG_SLOT4 = 11;

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        RECV = 1'b1
    } rx_state_t;

    // LSB position of slot n (n >= 1) inside an MSB-first RX_BITS shift register
    function automatic int slot_lsb(input int n);
        return RX_BITS - SLOT0_W - SLOT_W * n;
    endfunction

endpackage : ac97_pkg
`default_nettype wire

// File: rtl/ac97_edge_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ac97_edge_sync : synchronizes bit_clk/sync/sdata_in, strobes on bit_clk fall|
// | rev 1.0        : initial release                                           |
// +----------------------------------------------------------------------------+
module ac97_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic bit_clk,
    input  logic sync,
    input  logic sdata_in,
    output logic sample,
    output logic sync_s,
    output logic sdata_s
);

    logic [SYNC_STAGES-1:0] bclk_sr;
    logic [SYNC_STAGES-1:0] sync_sr;
    logic [SYNC_STAGES-1:0] sdat_sr;
    logic                   bclk_prev;

    // Equal-depth chains keep the three inputs mutually aligned after sync
    always_ff @(posedge clock) begin
        if (!reset) begin
            bclk_sr   <= '0;
            sync_sr   <= '0;
            sdat_sr   <= '0;
            bclk_prev <= 1'b0;
        end else begin
            bclk_sr   <= {bclk_sr[SYNC_STAGES-2:0], bit_clk};
            sync_sr   <= {sync_sr[SYNC_STAGES-2:0], sync};
            sdat_sr   <= {sdat_sr[SYNC_STAGES-2:0], sdata_in};
            bclk_prev <= bclk_sr[SYNC_STAGES-1];
        end
    end

    assign sample  = bclk_prev & ~bclk_sr[SYNC_STAGES-1];
    assign sync_s  = sync_sr[SYNC_STAGES-1];
    assign sdata_s = sdat_sr[SYNC_STAGES-1];

endmodule : ac97_edge_sync
`default_nettype wire

// File: rtl/ac97_sdin_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ac97_sdin_rx : AC97 SDATA_IN deserializer (tag, status, capture PCM)       |
// | Optional bit_clk stall watchdog: AC97_RX_BITCLK_WATCHDOG_EN                |
// | rev 1.0      : initial release                                             |
// +----------------------------------------------------------------------------+
module ac97_sdin_rx
    import ac97_pkg::*;
#(
`ifdef AC97_RX_BITCLK_WATCHDOG_EN
    parameter int WD_CYCLES   = 64,
`endif
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        bit_clk,
    input  logic        sync,
    input  logic        sdata_in,
    output logic        locked,
    output logic        codec_ready,
    output logic [15:0] tag,
    output logic [6:0]  status_addr,
    output logic [15:0] status_data,
    output logic        status_valid,
    output logic [19:0] pcm_left,
    output logic [19:0] pcm_right,
    output logic        pcm_valid,
    output logic        frame_err
);

    localparam int        TAG_LSB  = RX_BITS - SLOT0_W;
    localparam int        S1_LSB   = slot_lsb(1);
    localparam int        S2_LSB   = slot_lsb(2);
    localparam int        S3_LSB   = slot_lsb(3);
    localparam int        S4_LSB   = slot_lsb(4);
    localparam logic [7:0] LAST_CNT = 8'(FRAME_BITS - 1);
    localparam logic [7:0] PUB_CNT  = 8'(RX_LAST_BIT - 1);

    logic               sample;
    logic               sync_s;
    logic               sdata_s;
    logic               prev_sync;
    logic               frame_start;
    logic               wd_expired;

    rx_state_t          state;
    rx_state_t          state_next;
    logic [7:0]         bit_cnt;
    logic [7:0]         bit_cnt_next;
    logic [RX_BITS-1:0] shreg;
    logic [RX_BITS-1:0] shreg_next;
    logic               publish;
    logic               publish_next;
    logic               err_next;

    ac97_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clock    (clock),
        .reset    (reset),
        .bit_clk  (bit_clk),
        .sync     (sync),
        .sdata_in (sdata_in),
        .sample   (sample),
        .sync_s   (sync_s),
        .sdata_s  (sdata_s)
    );

    assign frame_start = sample & sync_s & ~prev_sync;

`ifdef AC97_RX_BITCLK_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;

    // Cycles since the last sample event, saturating so expiry fires only once
    always_ff @(posedge clock) begin
        if (!reset) begin
            wd_cnt <= '0;
        end else if (sample) begin
            wd_cnt <= '0;
        end else if (wd_cnt != WD_W'(WD_CYCLES)) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign wd_expired = (wd_cnt == WD_W'(WD_CYCLES));
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= HUNT;
            bit_cnt   <= '0;
            shreg     <= '0;
            publish   <= 1'b0;
            prev_sync <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            bit_cnt   <= bit_cnt_next;
            shreg     <= shreg_next;
            publish   <= publish_next;
            frame_err <= err_next;
            if (sample) begin
                prev_sync <= sync_s;
            end
        end
    end

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shreg_next   = shreg;
        publish_next = 1'b0;
        err_next     = 1'b0;

        if (wd_expired && (state == RECV) && !sample) begin
            state_next = HUNT;
            err_next   = 1'b1;
        end else if (sample) begin
            case (state)
                HUNT: begin
                    if (frame_start) begin
                        state_next   = RECV;
                        bit_cnt_next = '0;
                        shreg_next   = {shreg[RX_BITS-2:0], sdata_s};
                    end
                end
                RECV: begin
                    shreg_next = {shreg[RX_BITS-2:0], sdata_s};
                    if (frame_start) begin
                        // An early SYNC resynchronizes in place rather than hunting
                        bit_cnt_next = '0;
                        err_next     = (bit_cnt != LAST_CNT);
                    end else if (bit_cnt == LAST_CNT) begin
                        state_next = HUNT;
                        err_next   = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt + 8'd1;
                        publish_next = (bit_cnt == PUB_CNT);
                    end
                end
                default: begin
                    state_next = HUNT;
                end
            endcase
        end
    end

    assign locked = (state == RECV);

    always_ff @(posedge clock) begin
        if (!reset) begin
            codec_ready  <= 1'b0;
            tag          <= '0;
            status_addr  <= '0;
            status_data  <= '0;
            status_valid <= 1'b0;
            pcm_left     <= '0;
            pcm_right    <= '0;
            pcm_valid    <= 1'b0;
        end else begin
            status_valid <= 1'b0;
            pcm_valid    <= 1'b0;
            if (publish) begin
                codec_ready  <= shreg[TAG_LSB + TAG_READY];
                tag          <= shreg[TAG_LSB +: SLOT0_W];
                status_addr  <= shreg[S1_LSB + 12 +: 7];
                status_data  <= shreg[S2_LSB + 4 +: 16];
                pcm_left     <= shreg[S3_LSB +: SLOT_W];
                pcm_right    <= shreg[S4_LSB +: SLOT_W];
                status_valid <= shreg[TAG_LSB + TAG_SLOT1] & shreg[TAG_LSB + TAG_SLOT2];
                pcm_valid    <= shreg[TAG_LSB + TAG_SLOT3] & shreg[TAG_LSB + TAG_SLOT4];
            end
        end
    end

endmodule : ac97_sdin_rx
`default_nettype wire
